// File: rtl/tile_renderer.sv
// ---------------------------------------------------------------------------
// tile_renderer
//
// Pixel-generation stage that sits directly behind the VGA timing generator.
// Maps each raw (x, y) pixel onto a 5-column x 6-row letter-tile grid, fetches
// the glyph row for the tile's letter from an external 8x8 font ROM and emits
// a registered 12-bit RGB value. Sync and blank are delayed to stay aligned
// with the colour.
//
// Pipeline: inputs sampled in cycle N -> rgb/hsync_o/vsync_o/blank_o valid
// after edge N+2. font_addr is registered after edge N+1. The ROM answers
// combinationally from font_addr, so font_data is sampled at edge N+2.
//
// Ports
//   clk, rst              pixel clock, synchronous active-high reset
//   x, y                  pixel column / row from the timing generator
//   hsync, vsync, blank   timing signals (syncs active low)
//   wr_en, wr_row, wr_col tile write strobe and address (row 0..5, col 0..4)
//   wr_letter, wr_state   letter code (0 none, 1..26 A..Z) and colour state
//   font_addr, font_data  font ROM address {letter, glyph_row} / glyph row
//   rgb                   {r[3:0], g[3:0], b[3:0]}
//   hsync_o, vsync_o,
//   blank_o               timing signals delayed by 2 cycles
//
// Optional build macro CURSOR_EN: adds cursor_row, cursor_col and cursor_on.
// The tile under the cursor gets a 2-pixel white border that overrides the
// fill colour but not lit glyph pixels.
// ---------------------------------------------------------------------------
module tile_renderer #(
    parameter logic [10:0] X0        = 11'd140,
    parameter logic [10:0] Y0        = 11'd24,
    parameter logic [10:0] PITCH     = 11'd72,
    parameter logic [10:0] TILE      = 11'd64,
    parameter logic [10:0] GLYPH_OFF = 11'd16,
    parameter logic [11:0] BG_RGB    = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank,
    input  logic        wr_en,
    input  logic [2:0]  wr_row,
    input  logic [2:0]  wr_col,
    input  logic [4:0]  wr_letter,
    input  logic [1:0]  wr_state,
`ifdef CURSOR_EN
    input  logic [2:0]  cursor_row,
    input  logic [2:0]  cursor_col,
    input  logic        cursor_on,
`endif
    output logic [7:0]  font_addr,
    input  logic [7:0]  font_data,
    output logic [11:0] rgb,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o
);

    // 12-bit signed versions of the geometry so offsets can go negative.
    localparam logic signed [11:0] X0_S    = signed'({1'b0, X0});
    localparam logic signed [11:0] Y0_S    = signed'({1'b0, Y0});
    localparam logic signed [11:0] P1      = signed'({1'b0, PITCH});
    localparam logic signed [11:0] P2      = P1 + P1;
    localparam logic signed [11:0] P3      = P2 + P1;
    localparam logic signed [11:0] P4      = P3 + P1;
    localparam logic signed [11:0] P5      = P4 + P1;
    localparam logic signed [11:0] P6      = P5 + P1;
    localparam logic signed [11:0] TILE_S  = signed'({1'b0, TILE});
    localparam logic signed [11:0] GOFF_S  = signed'({1'b0, GLYPH_OFF});
    localparam logic signed [11:0] GEND_S  = GOFF_S + 12'sd32;
`ifdef CURSOR_EN
    localparam logic signed [11:0] BORD_HI = TILE_S - 12'sd2;
`endif

    // Tile index along one axis; constant compare chain instead of a divider.
    // Values past the last tile clamp to 5 and are rejected by the range test.
    function automatic logic [2:0] tile_of(input logic signed [11:0] d);
        if (d >= P5)      return 3'd5;
        else if (d >= P4) return 3'd4;
        else if (d >= P3) return 3'd3;
        else if (d >= P2) return 3'd2;
        else if (d >= P1) return 3'd1;
        else              return 3'd0;
    endfunction

    function automatic logic signed [11:0] base_of(input logic [2:0] t);
        case (t)
            3'd1:    return P1;
            3'd2:    return P2;
            3'd3:    return P3;
            3'd4:    return P4;
            3'd5:    return P5;
            default: return 12'sd0;
        endcase
    endfunction

    // Row-major flat index into the 30-entry register file.
    function automatic logic [4:0] tile_idx(input logic [2:0] r, input logic [2:0] c);
        return ({2'b00, r} * 5'd5) + {2'b00, c};
    endfunction

    function automatic logic [11:0] fill_rgb(input logic [1:0] st);
        case (st)
            2'd0:    return 12'h222;
            2'd1:    return 12'h444;
            2'd2:    return 12'hCA0;
            default: return 12'h4A4;
        endcase
    endfunction

    logic [4:0] letter_q [0:29];
    logic [1:0] state_q  [0:29];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 30; i++) begin
                letter_q[i] <= '0;
                state_q[i]  <= '0;
            end
        end else if (wr_en && (wr_row <= 3'd5) && (wr_col <= 3'd4)) begin
            letter_q[tile_idx(wr_row, wr_col)] <= wr_letter;
            state_q[tile_idx(wr_row, wr_col)]  <= wr_state;
        end
    end

    logic signed [11:0] dx_c, dy_c, ox_c, oy_c;
    logic [2:0]         col_c, row_c, gc_c, gr_c;
    logic [4:0]         rd_idx_c, letter_c;
    logic [1:0]         state_c;
    logic               in_x_c, in_y_c, in_tile_c, in_glyph_c;
`ifdef CURSOR_EN
    logic               border_c;
`endif

    always_comb begin
        dx_c     = signed'({1'b0, x}) - X0_S;
        dy_c     = signed'({1'b0, y}) - Y0_S;
        in_x_c   = (dx_c >= 12'sd0) && (dx_c < P5);
        in_y_c   = (dy_c >= 12'sd0) && (dy_c < P6);
        col_c    = tile_of(dx_c);
        row_c    = tile_of(dy_c);
        ox_c     = dx_c - base_of(col_c);
        oy_c     = dy_c - base_of(row_c);
        // Outside the grid the clamped indices could point past entry 29.
        rd_idx_c = (in_x_c && in_y_c) ? tile_idx(row_c, col_c) : 5'd0;
        letter_c = letter_q[rd_idx_c];
        state_c  = state_q[rd_idx_c];
        in_tile_c  = in_x_c && in_y_c && (ox_c < TILE_S) && (oy_c < TILE_S);
        in_glyph_c = in_tile_c && (ox_c >= GOFF_S) && (ox_c < GEND_S) &&
                     (oy_c >= GOFF_S) && (oy_c < GEND_S) && (letter_c != 5'd0);
        // Glyph is scaled x4, so each font bit covers 4x4 pixels.
        gc_c = 3'((ox_c - GOFF_S) >>> 2);
        gr_c = 3'((oy_c - GOFF_S) >>> 2);
`ifdef CURSOR_EN
        border_c = in_tile_c && cursor_on && (row_c == cursor_row) && (col_c == cursor_col) &&
                   ((ox_c < 12'sd2) || (ox_c >= BORD_HI) || (oy_c < 12'sd2) || (oy_c >= BORD_HI));
`endif
    end

    // ---- stage 1 boundary: tile lookup registered, font address issued ----
    logic [1:0] state_p1;
    logic       in_tile_p1, in_glyph_p1;
    logic [2:0] gc_p1;
    logic [7:0] font_addr_p1;
    logic       hs_p1, vs_p1, bl_p1;
`ifdef CURSOR_EN
    logic       border_p1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1     <= '0;
            in_tile_p1   <= 1'b0;
            in_glyph_p1  <= 1'b0;
            gc_p1        <= '0;
            font_addr_p1 <= '0;
            hs_p1        <= 1'b1;
            vs_p1        <= 1'b1;
            bl_p1        <= 1'b1;
`ifdef CURSOR_EN
            border_p1    <= 1'b0;
`endif
        end else begin
            state_p1     <= state_c;
            in_tile_p1   <= in_tile_c;
            in_glyph_p1  <= in_glyph_c;
            gc_p1        <= gc_c;
            font_addr_p1 <= {letter_c, gr_c};
            hs_p1        <= hsync;
            vs_p1        <= vsync;
            bl_p1        <= blank;
`ifdef CURSOR_EN
            border_p1    <= border_c;
`endif
        end
    end

    assign font_addr = font_addr_p1;

    logic        pixel_c;
    logic [11:0] rgb_c;

    always_comb begin
        rgb_c   = BG_RGB;
        pixel_c = font_data[3'd7 - gc_p1];
        if (bl_p1)
            rgb_c = 12'h000;
        else if (in_glyph_p1 && pixel_c)
            rgb_c = 12'hFFF;
`ifdef CURSOR_EN
        else if (border_p1)
            rgb_c = 12'hFFF;
`endif
        else if (in_tile_p1)
            rgb_c = fill_rgb(state_p1);
    end

    // ---- stage 2 boundary: colour and delayed timing registered ----
    logic [11:0] rgb_p2;
    logic        hs_p2, vs_p2, bl_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p2 <= '0;
            hs_p2  <= 1'b1;
            vs_p2  <= 1'b1;
            bl_p2  <= 1'b1;
        end else begin
            rgb_p2 <= rgb_c;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            bl_p2  <= bl_p1;
        end
    end

    assign rgb     = rgb_p2;
    assign hsync_o = hs_p2;
    assign vsync_o = vs_p2;
    assign blank_o = bl_p2;

endmodule

// File: tb/tb_tile_renderer.sv
// ---------------------------------------------------------------------------
// tb_tile_renderer
//
// Bench for tile_renderer. Each driven pixel pushes its expected colour and
// timing outputs into a queue; the entry is popped and compared two clock
// edges later. A table of pixel vectors covers the grid geometry, and a few
// hand-written sequences cover writes, sync delay and reset mid-frame.
// The font ROM model answers 8'hFF at address 8'h08 and 8'hC0 elsewhere.
// ---------------------------------------------------------------------------
module tb_tile_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x, y;
    logic        hsync, vsync, blank;
    logic        wr_en;
    logic [2:0]  wr_row, wr_col;
    logic [4:0]  wr_letter;
    logic [1:0]  wr_state;
    logic [7:0]  font_addr, font_data;
    logic [11:0] rgb;
    logic        hsync_o, vsync_o, blank_o;
`ifdef CURSOR_EN
    logic [2:0]  cursor_row = 3'd0;
    logic [2:0]  cursor_col = 3'd0;
    logic        cursor_on  = 1'b0;
`endif

    tile_renderer dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank     (blank),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_letter (wr_letter),
        .wr_state  (wr_state),
`ifdef CURSOR_EN
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .cursor_on (cursor_on),
`endif
        .font_addr (font_addr),
        .font_data (font_data),
        .rgb       (rgb),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .blank_o   (blank_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return (a == 8'h08) ? 8'hFF : 8'hC0;
    endfunction

    assign font_data = rom_f(font_addr);

    typedef struct {
        logic        chk;
        logic [11:0] rgb;
        logic        hs, vs, bl;
        string       name;
    } exp_t;

    typedef struct {
        int    x, y, bl, rgb, fchk, fa;
        string name;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one pixel for one clock; compare the output due from two cycles ago.
    task automatic cycle(input int px, input int py, input int phs, input int pvs, input int pbl,
                         input int chk, input int ergb, input int fchk, input int efa,
                         input string name);
        exp_t e;
        x     = 11'(px);
        y     = 11'(py);
        hsync = 1'(phs);
        vsync = 1'(pvs);
        blank = 1'(pbl);
        e.chk  = 1'(chk);
        e.rgb  = 12'(ergb);
        e.hs   = 1'(phs);
        e.vs   = 1'(pvs);
        e.bl   = 1'(pbl);
        e.name = name;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (fchk != 0) check({name, ".font_addr"}, 32'(font_addr), 32'(efa));
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            if (e.chk) begin
                check({e.name, ".rgb"},     32'(rgb),     32'(e.rgb));
                check({e.name, ".hsync_o"}, 32'(hsync_o), 32'(e.hs));
                check({e.name, ".vsync_o"}, 32'(vsync_o), 32'(e.vs));
                check({e.name, ".blank_o"}, 32'(blank_o), 32'(e.bl));
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 1, 1, 1, 0, 0, 0, 0, "idle");
    endtask

    task automatic pix(input vec_t v);
        cycle(v.x, v.y, 1, 1, v.bl, 1, v.rgb, v.fchk, v.fa, v.name);
    endtask

    task automatic wr(input int r, input int c, input int l, input int s);
        wr_en     = 1'b1;
        wr_row    = 3'(r);
        wr_col    = 3'(c);
        wr_letter = 5'(l);
        wr_state  = 2'(s);
        idle();
        wr_en     = 1'b0;
    endtask

    task automatic add(input int px, input int py, input int pbl, input int ergb,
                       input int fchk, input int efa, input string name);
        vec_t v;
        v.x = px; v.y = py; v.bl = pbl; v.rgb = ergb; v.fchk = fchk; v.fa = efa; v.name = name;
        vt.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Tiles: (0,0) letter 1 state 3, (0,1) letter 2 state 2, rest empty.
        add(156,  40, 0, 12'hFFF, 1, 8'h08, "glyph_A_r0c0");
        add(184,  40, 0, 12'hFFF, 1, 8'h08, "glyph_A_r0c7");
        add(187,  71, 0, 12'h4A4, 1, 8'h0F, "glyph_A_r7c7_off");
        add(150,  30, 0, 12'h4A4, 0, 0,     "fill_correct");
        add(140,  24, 0, 12'h4A4, 0, 0,     "tile_origin");
        add(203,  30, 0, 12'h4A4, 0, 0,     "tile_last_col");
        add(139,  30, 0, 12'h000, 0, 0,     "left_of_grid");
        add(150,  23, 0, 12'h000, 0, 0,     "above_grid");
        add(204,  30, 0, 12'h000, 0, 0,     "gap_x");
        add(100, 100, 0, 12'h000, 0, 0,     "outside");
        add(700,  30, 1, 12'h000, 0, 0,     "blank_outside");
        add(150,  30, 1, 12'h000, 0, 0,     "blank_over_tile");
        add(228,  44, 0, 12'hFFF, 1, 8'h11, "glyph_B_gc0");
        add(232,  44, 0, 12'hFFF, 0, 0,     "glyph_B_gc1");
        add(236,  44, 0, 12'hCA0, 0, 0,     "glyph_B_gc2");
        add(256,  44, 0, 12'hCA0, 0, 0,     "glyph_B_gc7");
        add(260,  44, 0, 12'hCA0, 0, 0,     "right_of_glyph");
        add(227,  44, 0, 12'hCA0, 0, 0,     "left_of_glyph");
        add(228,  39, 0, 12'hCA0, 0, 0,     "above_glyph");
        add(228,  71, 0, 12'hFFF, 1, 8'h17, "glyph_B_gr7");
        add(228,  72, 0, 12'hCA0, 0, 0,     "below_glyph");
        add(491,  30, 0, 12'h222, 0, 0,     "col4_last_px");
        add(492,  30, 0, 12'h000, 0, 0,     "col4_gap");
        add(500,  30, 0, 12'h000, 0, 0,     "right_of_grid");
        add(150, 447, 0, 12'h222, 0, 0,     "row5_last_px");
        add(150, 455, 0, 12'h000, 0, 0,     "row5_gap");
        add(150, 480, 0, 12'h000, 0, 0,     "below_grid");
        add(444, 400, 0, 12'h222, 0, 0,     "empty_letter_glyph_area");
        add(2047, 2047, 0, 12'h000, 0, 0,   "max_xy");

        rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_letter = '0; wr_state = '0;
        x = '0; y = '0; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.rgb",       32'(rgb),       32'h000);
        check("reset.hsync_o",   32'(hsync_o),   32'h1);
        check("reset.vsync_o",   32'(vsync_o),   32'h1);
        check("reset.blank_o",   32'(blank_o),   32'h1);
        check("reset.font_addr", 32'(font_addr), 32'h00);
        rst = 1'b0;

        // Empty grid: tile fill is the state-0 colour.
        cycle(150, 30, 1, 1, 0, 1, 12'h222, 0, 0, "empty_fill");
        wr(0, 0, 1, 3);
        wr(0, 1, 2, 2);
        foreach (vt[i]) pix(vt[i]);

        // Out-of-range writes leave the grid unchanged (row 0 col 5 would alias row 1 col 0).
        wr(6, 0, 5, 2);
        wr(0, 5, 5, 2);
        wr(7, 7, 5, 2);
        cycle(428, 384, 1, 1, 0, 1, 12'h222, 0, 0, "badwr_tile_r5c4");
        cycle(150, 102, 1, 1, 0, 1, 12'h222, 0, 0, "badwr_tile_r1c0");
        cycle(150,  30, 1, 1, 0, 1, 12'h4A4, 0, 0, "badwr_tile_r0c0");
        wr(5, 4, 0, 1);
        cycle(428, 384, 1, 1, 0, 1, 12'h444, 0, 0, "wr_r5c4_absent");

        // Write and scan the same tile in one cycle: old state, then new.
        wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_letter = 5'd1; wr_state = 2'd2;
        cycle(150, 30, 1, 1, 0, 1, 12'h4A4, 0, 0, "same_cycle_old");
        wr_en = 1'b0;
        cycle(150, 30, 1, 1, 0, 1, 12'hCA0, 0, 0, "same_cycle_new");

        // hsync pulse over x=656..751 must reappear with identical width.
        for (int px = 650; px <= 760; px++)
            cycle(px, 30, (px >= 656 && px <= 751) ? 0 : 1, 1, 1, 1, 12'h000, 0, 0, "hsync_pulse");
        for (int i = 0; i < 10; i++)
            cycle(700, 490 + i, 1, (i >= 2 && i <= 3) ? 0 : 1, 1, 1, 12'h000, 0, 0, "vsync_pulse");

        // Reset mid-tile while outputs hold non-reset values.
        cycle(150, 30, 0, 0, 0, 1, 12'hCA0, 0, 0, "pre_reset");
        cycle(150, 30, 0, 0, 0, 1, 12'hCA0, 0, 0, "pre_reset");
        cycle(150, 30, 0, 0, 0, 1, 12'hCA0, 0, 0, "pre_reset");
        sbq.delete();
        x = 11'd156; y = 11'd40; hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.rgb",       32'(rgb),       32'h000);
        check("midrst.hsync_o",   32'(hsync_o),   32'h1);
        check("midrst.vsync_o",   32'(vsync_o),   32'h1);
        check("midrst.blank_o",   32'(blank_o),   32'h1);
        check("midrst.font_addr", 32'(font_addr), 32'h00);
        rst = 1'b0;
        cycle(150, 30, 1, 1, 0, 1, 12'h222, 0, 0,     "post_reset_fill");
        cycle(156, 40, 1, 1, 0, 1, 12'h222, 1, 8'h00, "post_reset_no_glyph");
        cycle(236, 44, 0, 1, 0, 1, 12'h222, 0, 0,     "post_reset_r0c1");
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
